// File: rtl/sar_seq_ctrl.sv
// sar_seq_ctrl: successive-approximation ADC sequencer with sample/convert/done flow and optional channel auto-scan
module sar_seq_ctrl #(
    parameter int WIDTH      = 12,
    parameter int NCH        = 4,
    parameter int SAMPLE_CYC = 2,
    parameter int SETTLE     = 1,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             scan,
    input  logic [CHW-1:0]   ch_sel,
    input  logic             cmp,
    input  logic             result_ack,
    output logic             sample,
    output logic [CHW-1:0]   ch_out,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [CHW-1:0]   result_ch,
    output logic             conv_done,
    output logic             result_valid,
    output logic             overrun
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SAMPLE  = 2'd1;
    localparam logic [1:0] CONVERT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [7:0] SMP_LAST = 8'(SAMPLE_CYC - 1);
    localparam logic [7:0] SET_LAST = 8'(SETTLE - 1);
    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CHW-1:0]   rch_q, rch_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] kept;
    // next-state: phase sequencing, bit trials and result bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        dac_d   = dac_q;
        ch_d    = ch_q;
        res_d   = res_q;
        rch_d   = rch_q;
        valid_d = result_ack ? 1'b0 : valid_q;
        ovr_d   = ovr_q;
        kept    = cmp ? dac_q : (dac_q & ~(ONE << bit_q));
        case (state_q)
            IDLE: begin
                dac_d = '0;
                if (start) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                    ch_d    = ch_sel;
                end
            end
            SAMPLE: begin
                dac_d = '0;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SMP_LAST) begin
                    state_d = CONVERT;
                    cnt_d   = '0;
                    bit_d   = BW'(WIDTH - 1);
                    dac_d   = ONE << (WIDTH - 1);
                end
            end
            CONVERT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SET_LAST) begin
                    cnt_d = '0;
                    if (bit_q == '0) begin
                        state_d = DONE;
                        dac_d   = kept;
                        res_d   = kept;
                        rch_d   = ch_q;
                    end else begin
                        bit_d = bit_q - 1'b1;
                        dac_d = kept | (ONE << (bit_q - 1'b1));
                    end
                end
            end
            default: begin
                valid_d = 1'b1;
                ovr_d   = ovr_q | (valid_q & ~result_ack);
                dac_d   = '0;
                cnt_d   = '0;
                state_d = scan ? SAMPLE : IDLE;
                ch_d    = scan ? ((ch_q == CHW'(NCH - 1)) ? '0 : ch_q + 1'b1) : ch_q;
            end
        endcase
    end
    // state registers with synchronous reset discarding any conversion
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            dac_q   <= '0;
            ch_q    <= '0;
            res_q   <= '0;
            rch_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            dac_q   <= dac_d;
            ch_q    <= ch_d;
            res_q   <= res_d;
            rch_q   <= rch_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end
    assign sample       = state_q == SAMPLE;
    assign busy         = state_q != IDLE;
    assign conv_done    = state_q == DONE;
    assign ch_out       = ch_q;
    assign dac_code     = dac_q;
    assign result       = res_q;
    assign result_ch    = rch_q;
    assign result_valid = valid_q;
    assign overrun      = ovr_q;
endmodule

// File: tb/tb_sar_seq_ctrl.sv
// tb_sar_seq_ctrl: directed and randomized checks of sar_seq_ctrl against a cycle-offset reference model
module tb_sar_seq_ctrl;
    localparam int W = 12, NC = 4, S = 2, SET = 1;
    localparam int D = S + W * SET;
    logic clk = 0, reset = 1, start = 0, scan = 0, result_ack = 0;
    logic [1:0] ch_sel = 0;
    logic [1:0] cmp_mode = 0;
    logic rnd_bit = 0;
    logic [11:0] vin = 0;
    logic cmp;
    logic sample, busy, conv_done, result_valid, overrun;
    logic [1:0] ch_out, result_ch;
    logic [11:0] dac_code, result;
    logic start3 = 0;
    logic [11:0] vin3 = 0;
    logic cmp3;
    logic sample3, busy3, conv_done3, result_valid3, overrun3;
    logic [1:0] ch_out3, result_ch3;
    logic [11:0] dac_code3, result3;
    int n_pass = 0, n_total = 0, cyc = 0;
    bit chk_en = 0;
    logic cmp_s = 0;
    int m_act = 0, m_k = 0, m_ch = 0, m_kept = 0, m_res = 0, m_rch = 0, m_valid = 0, m_ovr = 0;

    assign cmp  = (cmp_mode == 0) ? (vin >= dac_code) : (cmp_mode == 1) ? 1'b1 : (cmp_mode == 2) ? 1'b0 : rnd_bit;
    assign cmp3 = vin3 >= dac_code3;

    sar_seq_ctrl #(.WIDTH(W), .NCH(NC), .SAMPLE_CYC(S), .SETTLE(SET)) u_dut (
        .clk(clk), .reset(reset), .start(start), .scan(scan), .ch_sel(ch_sel), .cmp(cmp),
        .result_ack(result_ack), .sample(sample), .ch_out(ch_out), .dac_code(dac_code), .busy(busy),
        .result(result), .result_ch(result_ch), .conv_done(conv_done), .result_valid(result_valid),
        .overrun(overrun));

    sar_seq_ctrl #(.WIDTH(W), .NCH(NC), .SAMPLE_CYC(S), .SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .scan(1'b0), .ch_sel(2'd1), .cmp(cmp3),
        .result_ack(1'b0), .sample(sample3), .ch_out(ch_out3), .dac_code(dac_code3), .busy(busy3),
        .result(result3), .result_ch(result_ch3), .conv_done(conv_done3), .result_valid(result_valid3),
        .overrun(overrun3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // reference model: tracks conversion progress as an offset from the start of sampling
    always @(posedge clk) begin
        if (reset) begin
            chk_en = 1;
            m_act = 0; m_k = 0; m_ch = 0; m_kept = 0; m_res = 0; m_rch = 0; m_valid = 0; m_ovr = 0;
        end else begin
            automatic bit done = (m_act != 0) && (m_k == D);
            if (done) begin
                if (m_valid != 0 && !result_ack) m_ovr = 1;
                m_valid = 1;
            end else if (result_ack) m_valid = 0;
            if (m_act == 0) begin
                if (start) begin m_act = 1; m_k = 0; m_ch = int'(ch_sel); m_kept = 0; end
            end else if (done) begin
                if (scan) begin m_k = 0; m_ch = (m_ch == NC - 1) ? 0 : m_ch + 1; m_kept = 0; end
                else m_act = 0;
            end else begin
                if (m_k >= S && (m_k - S) % SET == SET - 1 && cmp_s)
                    m_kept = m_kept | (1 << (W - 1 - (m_k - S) / SET));
                if (m_k == D - 1) begin m_res = m_kept; m_rch = m_ch; end
                m_k++;
            end
        end
    end

    // compare every cycle, away from the clock edge
    always @(negedge clk) begin
        cmp_s = cmp;
        if (chk_en) begin
            automatic int e_dac = 0;
            if (m_act != 0 && m_k >= S && m_k < D) e_dac = m_kept | (1 << (W - 1 - (m_k - S) / SET));
            chk("sample", int'(sample), int'(m_act != 0 && m_k < S));
            chk("busy", int'(busy), m_act);
            chk("conv_done", int'(conv_done), int'(m_act != 0 && m_k == D));
            chk("ch_out", int'(ch_out), m_ch);
            if (!(m_act != 0 && m_k == D)) chk("dac_code", int'(dac_code), e_dac);
            chk("result", int'(result), m_res);
            chk("result_ch", int'(result_ch), m_rch);
            chk("result_valid", int'(result_valid), m_valid);
            chk("overrun", int'(overrun), m_ovr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic wait_done(output int c);
        c = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (conv_done) begin c = cyc; break; end
        end
        step();
    endtask

    task automatic conv(input logic [1:0] ch, output int lat);
        int t, c;
        ch_sel = ch;
        start = 1;
        t = cyc;
        step();
        start = 0;
        wait_done(c);
        lat = (c < 0) ? -1 : c - t;
    endtask

    initial begin
        int t, c, lat, cnt;
        int dc[5];
        int rc[5];
        int exp_rc[5];
        exp_rc = '{3, 0, 1, 2, 3};
        #1;
        reset = 1; start = 1;
        step(); step();
        reset = 0; start = 0;
        chk("busy after reset with start", int'(busy), 0);
        chk("result_valid after reset", int'(result_valid), 0);

        cmp_mode = 0; vin = 12'hA5C; ch_sel = 2; start = 1; t = cyc;
        step(); start = 0;
        chk("sample T+1", int'(sample), 1);
        step();
        chk("sample T+2", int'(sample), 1);
        step();
        chk("dac T+3", int'(dac_code), 'h800);
        step();
        chk("dac T+4", int'(dac_code), 'hC00);
        step();
        chk("dac T+5", int'(dac_code), 'hA00);
        wait_done(c);
        chk("latency", c - t, 15);
        chk("result A5C", int'(result), 'hA5C);
        chk("result_ch 2", int'(result_ch), 2);
        chk("valid after done", int'(result_valid), 1);
        chk("no overrun", int'(overrun), 0);

        cmp_mode = 1; conv(1, lat);
        chk("cmp1 result", int'(result), 'hFFF);
        cmp_mode = 2; conv(0, lat);
        chk("cmp0 result", int'(result), 0);
        chk("overrun after unacked results", int'(overrun), 1);

        do_reset();
        cmp_mode = 3; scan = 1; ch_sel = 3; start = 1;
        step(); start = 0;
        for (int i = 0; i < 5; i++) begin
            wait_done(dc[i]);
            rc[i] = int'(result_ch);
            chk("scan result_ch", rc[i], exp_rc[i]);
            if (i > 0) chk("scan spacing", dc[i] - dc[i-1], 15);
        end
        scan = 0;
        wait_done(c);
        chk("scan stop last spacing", c - dc[4], 15);
        step(); step();
        chk("idle after scan stop", int'(busy), 0);

        do_reset();
        cmp_mode = 0; vin = 12'(32'($urandom_range(0, 4095)));
        conv(0, lat);
        chk("first no overrun", int'(overrun), 0);
        conv(1, lat);
        chk("overrun set", int'(overrun), 1);

        do_reset();
        conv(2, lat);
        ch_sel = 1; start = 1; t = cyc;
        step(); start = 0;
        repeat (14) step();
        chk("done at T+15", int'(conv_done), 1);
        result_ack = 1;
        step();
        result_ack = 0;
        chk("ack+done valid", int'(result_valid), 1);
        chk("ack+done no overrun", int'(overrun), 0);

        do_reset();
        vin = 12'(32'($urandom_range(1, 4095)));
        conv(3, lat);
        ch_sel = 3; start = 1;
        step(); start = 0;
        repeat (8) step();
        reset = 1;
        step();
        reset = 0;
        chk("rst busy", int'(busy), 0);
        chk("rst sample", int'(sample), 0);
        chk("rst dac", int'(dac_code), 0);
        chk("rst ch_out", int'(ch_out), 0);
        chk("rst result", int'(result), 0);
        chk("rst result_ch", int'(result_ch), 0);
        chk("rst valid", int'(result_valid), 0);
        vin = 12'h3A7;
        conv(1, lat);
        chk("post-reset latency", lat, 15);
        chk("post-reset result", int'(result), 'h3A7);

        ch_sel = 1; start = 1;
        step(); start = 0;
        repeat (5) step();
        ch_sel = 2; start = 1;
        step(); start = 0;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (conv_done) cnt++;
        end
        step();
        chk("single done", cnt, 1);
        chk("original channel", int'(result_ch), 1);

        vin3 = 12'h3C5; start3 = 1; t = cyc;
        step(); start3 = 0;
        c = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (conv_done3) begin c = cyc; break; end
        end
        step();
        chk("settle3 latency", (c < 0) ? -1 : c - t, 39);
        chk("settle3 result", int'(result3), 'h3C5);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) begin
                cmp_mode = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
                vin = 12'(32'($urandom_range(0, 4095)));
            end
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            scan = ($urandom_range(0, 2) == 0);
            ch_sel = 2'(32'($urandom_range(0, 3)));
            result_ack = ($urandom_range(0, 2) == 0);
            rnd_bit = 1'($urandom_range(0, 1));
            step();
        end
        reset = 0; start = 0; result_ack = 0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
